// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache tag array: geometry helpers,
// default geometry, per-line state record and one-hot/priority helpers.
package cache_pkg;

    localparam int DEF_WAYS       = 4;
    localparam int DEF_SETS       = 128;
    localparam int DEF_LINE_BYTES = 32;

    // Valid/dirty state kept per line
    typedef struct packed {
        logic valid;
        logic dirty;
    } line_st_t;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int sets, input int line_bytes);
        return addr_w - $clog2(sets) - $clog2(line_bytes);
    endfunction

    // Index of the set bit of a one-hot vector (up to 8 ways)
    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

    // Index of the lowest set bit (0 when none is set)
    function automatic logic [2:0] first_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cache_tag_nway_if.sv
// Request/response bundle between the cache pipeline and the tag array.
// Extra invalidate signals exist only when CACHE_TAG_INDEX_INV_EN is defined.
interface cache_tag_nway_if #(
    parameter int WAYS   = 4,
    parameter int ADDR_W = 32
);
    logic              flush;
    logic              req_en;
    logic              req_wen;
    logic              req_cached;
    logic [ADDR_W-1:0] req_addr;
    logic              refill_done;
    logic [WAYS-1:0]   hit;
    logic              miss;
    logic              stallreq;
    logic [WAYS-1:0]   victim;
    logic              write_back;
    logic [ADDR_W-1:0] axi_raddr;
    logic [ADDR_W-1:0] axi_waddr;
`ifdef CACHE_TAG_INDEX_INV_EN
    logic              inv_en;
    logic              inv_wb;
    logic [ADDR_W-1:0] inv_addr;
`endif

    modport master (
        output flush, req_en, req_wen, req_cached, req_addr, refill_done,
`ifdef CACHE_TAG_INDEX_INV_EN
        output inv_en, inv_wb, inv_addr,
`endif
        input  hit, miss, stallreq, victim, write_back, axi_raddr, axi_waddr
    );

    modport slave (
        input  flush, req_en, req_wen, req_cached, req_addr, refill_done,
`ifdef CACHE_TAG_INDEX_INV_EN
        input  inv_en, inv_wb, inv_addr,
`endif
        output hit, miss, stallreq, victim, write_back, axi_raddr, axi_waddr
    );

endinterface

// File: rtl/cache_tag_nway_plru_tree.sv
// Tree pseudo-LRU for one set: victim way and the node bits after an access.
// Nodes are heap ordered (root 0, children 2n+1 / 2n+2); a node bit of 0
// means its left subtree is the older one.
module plru_tree #(
    parameter int WAYS = 4,
    localparam int LV  = $clog2(WAYS)
) (
    input  logic [WAYS-2:0] bits_i,
    input  logic [LV-1:0]   way_i,
    output logic [LV-1:0]   victim_o,
    output logic [WAYS-2:0] bits_o
);
    localparam logic [WAYS-2:0] NODE0 = (WAYS-1)'(1);

    // Walk toward the older side for the victim; point every node on the
    // accessed way's path away from it for the update
    always_comb begin
        int              n;
        logic [WAYS-2:0] sh;
        logic [LV-1:0]   wsh;
        logic            d;
        n      = 0;
        sh     = '0;
        wsh    = '0;
        d      = 1'b0;
        bits_o = bits_i;
        for (int l = 0; l < LV; l++) begin
            sh = bits_i >> n;
            n  = sh[0] ? 2*n + 2 : 2*n + 1;
        end
        victim_o = LV'(n - (WAYS-1));
        n = 0;
        for (int l = 0; l < LV; l++) begin
            wsh = way_i >> (LV-1-l);
            d   = wsh[0];
            if (d) bits_o = bits_o & ~(NODE0 << n);
            else   bits_o = bits_o | (NODE0 << n);
            n = 2*n + 1 + int'(d);
        end
    end

endmodule

// File: rtl/cache_tag_nway.sv
// N-way set-associative tag/state array. A lookup is registered, all ways
// are compared one cycle later, and hit/miss/victim/write-back information
// is reported. Optional index invalidate: define CACHE_TAG_INDEX_INV_EN.
module cache_tag_nway
    import cache_pkg::*;
#(
    parameter int WAYS       = DEF_WAYS,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int ADDR_W     = 32
) (
    input logic             clk,
    input logic             rst,
    cache_tag_nway_if.slave bus
);
    localparam int OFF_W = off_w(LINE_BYTES);
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_BYTES);
    localparam int LV    = $clog2(WAYS);
    localparam logic [WAYS-1:0] WAY0 = WAYS'(1);

    logic [TAG_W-1:0]  tag_mem [WAYS][SETS];
    line_st_t          st_q    [WAYS][SETS];
    logic [WAYS-2:0]   plru_q  [SETS];
    logic [TAG_W-1:0]  rtag_q  [WAYS];
    logic [TAG_W-1:0]  rtag_d  [WAYS];
    logic              en_q, wen_q, cached_q;
    logic [ADDR_W-1:0] addr_q;

    logic [IDX_W-1:0]  idx_r, req_idx, rd_idx;
    logic [TAG_W-1:0]  tag_r;
    logic [WAYS-1:0]   valid_v, dirty_v, hit_raw, hit;
    logic              miss_raw, miss, accept, refill, req_blk, wb_miss;
    logic [LV-1:0]     hit_idx, vict_idx, plru_vict, acc_idx;
    logic [WAYS-2:0]   plru_nxt;
    logic [ADDR_W-1:0] waddr_miss;

    assign idx_r   = addr_q[OFF_W +: IDX_W];
    assign tag_r   = addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx = bus.req_addr[OFF_W +: IDX_W];

    // Per-way state of the registered index and the raw tag comparison
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            valid_v[w] = st_q[w][idx_r].valid;
            dirty_v[w] = st_q[w][idx_r].dirty;
            hit_raw[w] = st_q[w][idx_r].valid && (rtag_q[w] == tag_r) && cached_q && en_q;
        end
    end

    // Raw miss ignores flush so a refill arriving with flush is still written
    assign miss_raw = en_q & cached_q & ~|hit_raw;
    assign miss     = miss_raw & ~bus.flush;
    assign hit      = bus.flush ? '0 : hit_raw;
    assign hit_idx  = LV'(oh2idx(8'(hit_raw)));
    assign vict_idx = (&valid_v) ? plru_vict : LV'(first_set(8'(~valid_v)));
    assign refill   = bus.refill_done & miss_raw;
    assign acc_idx  = refill ? vict_idx : hit_idx;
    assign accept   = bus.req_en & ~miss & ~req_blk;
    assign rd_idx   = accept ? req_idx : idx_r;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits_i   (plru_q[idx_r]),
        .way_i    (acc_idx),
        .victim_o (plru_vict),
        .bits_o   (plru_nxt)
    );

    // Tag read for the next compare; a tag written this cycle is forwarded
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            if (refill && vict_idx == LV'(w) && rd_idx == idx_r) rtag_d[w] = tag_r;
            else                                                  rtag_d[w] = tag_mem[w][rd_idx];
        end
    end

    // Stage-1 request register; holds while a miss is pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            wen_q    <= 1'b0;
            cached_q <= 1'b0;
            addr_q   <= '0;
            for (int w = 0; w < WAYS; w++) rtag_q[w] <= '0;
        end else begin
            en_q <= accept | miss;
            if (accept) begin
                wen_q    <= bus.req_wen;
                cached_q <= bus.req_cached;
                addr_q   <= bus.req_addr;
            end
            if (accept | refill) begin
                for (int w = 0; w < WAYS; w++) rtag_q[w] <= rtag_d[w];
            end
        end
    end

    // Tag RAM write on refill (no reset; content ignored while invalid)
    always_ff @(posedge clk) begin
        if (refill) tag_mem[vict_idx][idx_r] <= tag_r;
    end

`ifdef CACHE_TAG_INDEX_INV_EN
    logic [WAYS-1:0]  wbm_q, inv_dirty;
    logic [IDX_W-1:0] inv_idx, widx_q;
    logic [TAG_W-1:0] wtag_q [WAYS];
    logic [LV-1:0]    wsel;
    logic             inv_go, inv_busy;

    assign inv_idx  = bus.inv_addr[OFF_W +: IDX_W];
    assign inv_busy = |wbm_q;
    assign inv_go   = bus.inv_en & ~miss & ~inv_busy;
    assign req_blk  = bus.inv_en | inv_busy;
    assign wsel     = LV'(first_set(8'(wbm_q)));

    // Dirty ways at the invalidate index
    always_comb begin
        for (int w = 0; w < WAYS; w++) inv_dirty[w] = st_q[w][inv_idx].dirty;
    end

    // Capture dirty ways and their tags, then retire one per acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbm_q  <= '0;
            widx_q <= '0;
            for (int w = 0; w < WAYS; w++) wtag_q[w] <= '0;
        end else if (inv_go) begin
            wbm_q  <= bus.inv_wb ? inv_dirty : '0;
            widx_q <= inv_idx;
            for (int w = 0; w < WAYS; w++) wtag_q[w] <= tag_mem[w][inv_idx];
        end else if (bus.refill_done && inv_busy) begin
            wbm_q <= wbm_q & ~(WAY0 << wsel);
        end
    end
`else
    assign req_blk = 1'b0;
`endif

    // Valid/dirty and PLRU updates from refills and hits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) st_q[w][s] <= '0;
            end
        end else begin
            if (refill) begin
                st_q[vict_idx][idx_r] <= line_st_t'{valid: 1'b1, dirty: wen_q};
                plru_q[idx_r]         <= plru_nxt;
            end else if (|hit) begin
                plru_q[idx_r] <= plru_nxt;
                if (wen_q) st_q[hit_idx][idx_r].dirty <= 1'b1;
            end
`ifdef CACHE_TAG_INDEX_INV_EN
            if (inv_go) begin
                for (int w = 0; w < WAYS; w++) st_q[w][inv_idx] <= '0;
            end
`endif
        end
    end

    assign wb_miss        = miss & valid_v[vict_idx] & dirty_v[vict_idx];
    assign waddr_miss     = miss ? {rtag_q[vict_idx], idx_r, {OFF_W{1'b0}}} : '0;
    assign bus.hit        = hit;
    assign bus.miss       = miss;
    assign bus.victim     = miss ? (WAY0 << vict_idx) : '0;
    assign bus.axi_raddr  = cached_q ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : addr_q;
`ifdef CACHE_TAG_INDEX_INV_EN
    assign bus.stallreq   = miss | inv_busy;
    assign bus.write_back = wb_miss | inv_busy;
    assign bus.axi_waddr  = inv_busy ? {wtag_q[wsel], widx_q, {OFF_W{1'b0}}} : waddr_miss;
`else
    assign bus.stallreq   = miss;
    assign bus.write_back = wb_miss;
    assign bus.axi_waddr  = waddr_miss;
`endif

endmodule

// File: tb/tb_cache_tag_nway.sv
// Self-checking bench for cache_tag_nway (4 ways, 128 sets, 32-byte lines).
module tb_cache_tag_nway;
    localparam int WAYS = 4;
    localparam int SETS = 128;

    logic clk;
    logic rst;

    cache_tag_nway_if #(.WAYS(WAYS), .ADDR_W(32)) bus ();

    cache_tag_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(32), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: line tables, PLRU node bits (1-based heap), pending request
    bit        m_valid [WAYS][SETS];
    bit        m_dirty [WAYS][SETS];
    bit [19:0] m_tag   [WAYS][SETS];
    bit        m_node  [SETS][2*WAYS];
    bit        p_en, p_wen, p_cached;
    bit [31:0] p_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[w][s] = 0;
                m_dirty[w][s] = 0;
            end
            for (int k = 0; k < 2*WAYS; k++) m_node[s][k] = 0;
        end
        p_en = 0; p_wen = 0; p_cached = 0; p_addr = '0;
    endfunction

    // Halve the way range following the older side
    function automatic int plru_victim(input int s);
        int lo, hi, node, mid;
        lo = 0; hi = WAYS; node = 1;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_node[s][node] == 0) begin hi = mid; node = 2*node; end
            else begin lo = mid; node = 2*node + 1; end
        end
        return lo;
    endfunction

    // Make way w most recently used in set s
    function automatic void plru_touch(input int s, input int w);
        int lo, hi, node, mid;
        lo = 0; hi = WAYS; node = 1;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w < mid) begin m_node[s][node] = 1; hi = mid; node = 2*node; end
            else begin m_node[s][node] = 0; lo = mid; node = 2*node + 1; end
        end
    endfunction

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin : cmp
        bit [6:0]  idx;
        bit [19:0] tg;
        int        v, hw;
        bit        raw_any, miss_raw, e_miss, found, e_wb;
        bit [3:0]  e_hit, e_vic;
        bit [31:0] e_raddr;
        if (rst) model_reset();
        idx = p_addr[11:5];
        tg  = p_addr[31:12];
        raw_any = 0; hw = 0; e_hit = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (p_en && p_cached && m_valid[w][idx] && m_tag[w][idx] == tg) begin
                raw_any = 1; hw = w;
            end
        end
        if (raw_any && !bus.flush) e_hit[hw] = 1'b1;
        miss_raw = p_en && p_cached && !raw_any;
        e_miss   = miss_raw && !bus.flush;
        found = 0; v = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !m_valid[w][idx]) begin v = w; found = 1; end
        end
        if (!found) v = plru_victim(int'(idx));
        e_wb    = e_miss && m_valid[v][idx] && m_dirty[v][idx];
        e_vic   = e_miss ? (4'b0001 << v) : 4'b0000;
        e_raddr = p_cached ? {p_addr[31:5], 5'b0} : p_addr;
        chk("hit", bus.hit, e_hit);
        chk("miss", bus.miss, e_miss);
        chk("stallreq", bus.stallreq, e_miss);
        chk("victim", bus.victim, e_vic);
        chk("write_back", bus.write_back, e_wb);
        chk("axi_raddr", bus.axi_raddr, e_raddr);
        if (rst) chk("rst_axi_waddr", bus.axi_waddr, 32'h0);
        else if (e_miss && m_valid[v][idx]) chk("axi_waddr", bus.axi_waddr, {m_tag[v][idx], idx, 5'b0});
        if (!rst) begin
            if (bus.refill_done && miss_raw) begin
                m_tag[v][idx]   = tg;
                m_valid[v][idx] = 1;
                m_dirty[v][idx] = p_wen;
                plru_touch(int'(idx), v);
            end else if (e_hit != 0) begin
                plru_touch(int'(idx), hw);
                if (p_wen) m_dirty[hw][idx] = 1;
            end
            if (bus.req_en && !e_miss) begin
                p_en = 1; p_addr = bus.req_addr; p_wen = bus.req_wen; p_cached = bus.req_cached;
            end else begin
                p_en = e_miss;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input bit w, input bit c);
        bus.req_en = 1'b1; bus.req_addr = a; bus.req_wen = w; bus.req_cached = c;
        cyc();
        bus.req_en = 1'b0; bus.req_wen = 1'b0;
        #1;
    endtask

    task automatic refill();
        bus.refill_done = 1'b1;
        cyc();
        bus.refill_done = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 0; bus.req_en = 0; bus.req_wen = 0; bus.req_cached = 0;
        bus.req_addr = '0; bus.refill_done = 0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // First access after reset misses into way 0
        req(32'h0000_1040, 0, 1);
        chk("t1_miss", bus.miss, 1);
        chk("t1_victim", bus.victim, 4'b0001);
        chk("t1_wb", bus.write_back, 0);
        chk("t1_raddr", bus.axi_raddr, 32'h0000_1040);
        refill();
        chk("t1_hit", bus.hit, 4'b0001);
        chk("t1_miss_after", bus.miss, 0);

        // Fill index 2 with tags 2..4, touch way 0, miss picks way 2
        for (int t = 2; t <= 4; t++) begin
            req({20'(t), 7'd2, 5'd0}, 0, 1);
            refill();
        end
        req(32'h0000_1040, 0, 1);
        chk("t2_hit0", bus.hit, 4'b0001);
        req(32'h0000_5040, 0, 1);
        chk("t2_miss", bus.miss, 1);
        chk("t2_victim", bus.victim, 4'b0100);
        chk("t2_wb", bus.write_back, 0);
        refill();

        // Store hit on way 1, steer PLRU back to way 1, evict it dirty
        req(32'h0000_2040, 1, 1);
        chk("t3_hit1", bus.hit, 4'b0010);
        req(32'h0000_1040, 0, 1);
        req(32'h0000_4040, 0, 1);
        chk("t3_hit3", bus.hit, 4'b1000);
        req(32'h0000_6040, 0, 1);
        chk("t3_victim", bus.victim, 4'b0010);
        chk("t3_wb", bus.write_back, 1);
        chk("t3_waddr", bus.axi_waddr, 32'h0000_2040);
        refill();

        // Uncached access
        req(32'h1FC0_0004, 0, 0);
        chk("t4_hit", bus.hit, 0);
        chk("t4_miss", bus.miss, 0);
        chk("t4_raddr", bus.axi_raddr, 32'h1FC0_0004);

        // Flush together with refill: line written, result suppressed
        req(32'h0000_7040, 0, 1);
        chk("t5_miss", bus.miss, 1);
        bus.refill_done = 1'b1; bus.flush = 1'b1;
        #1;
        chk("t5_miss_flush", bus.miss, 0);
        chk("t5_hit_flush", bus.hit, 0);
        chk("t5_wb_flush", bus.write_back, 0);
        cyc();
        bus.refill_done = 1'b0; bus.flush = 1'b0;
        req(32'h0000_7040, 0, 1);
        chk("t5_rehit", bus.hit, 4'b0100);
        chk("t5_remiss", bus.miss, 0);

        // Reset in the middle of a miss
        req(32'h0000_8040, 0, 1);
        chk("t6_miss", bus.miss, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_miss", bus.miss, 0);
        chk("t6_rst_victim", bus.victim, 0);
        chk("t6_rst_stall", bus.stallreq, 0);
        chk("t6_rst_raddr", bus.axi_raddr, 0);
        chk("t6_rst_waddr", bus.axi_waddr, 0);
        cyc();
        rst = 1'b0;
        req(32'h0000_6040, 0, 1);
        chk("t6_post_miss", bus.miss, 1);
        refill();

        // Randomized traffic on two indices and a few tags
        for (int i = 0; i < 3000; i++) begin
            bus.req_en      = ($urandom_range(0, 9) < 6);
            bus.req_addr    = {20'($urandom_range(1, 6)), 7'($urandom_range(2, 3)), 5'($urandom_range(0, 31))};
            bus.req_wen     = ($urandom_range(0, 9) < 3);
            bus.req_cached  = ($urandom_range(0, 19) < 17);
            bus.refill_done = ($urandom_range(0, 3) == 0);
            bus.flush       = ($urandom_range(0, 19) == 0);
            rst             = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 0; bus.req_en = 0; bus.refill_done = 0; bus.flush = 0;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_tag_nway.md
Name:
cache_tag_nway

Overview:
- Parametrised N-way set-associative tag/state array for the L1 I/D caches; next generation of the 2-way tag block.
- Registers a lookup, compares all ways one cycle later, and reports hit way, miss, victim way, write-back need and line addresses to the cache-data and AXI bridge blocks.
- Adds per-line dirty bits, invalid-first victim selection, tree pseudo-LRU and an explicit refill handshake.

Parameters:
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 128, sets per way; power of two.
- LINE_BYTES, 32, bytes per line; power of two, at least 4.
- ADDR_W, 32, address width.
- Derived:
  - OFF_W = log2(LINE_BYTES)
  - IDX_W = log2(SETS)
  - TAG_W = ADDR_W-IDX_W-OFF_W

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush; kills the pending lookup result
- req_en  in  1  lookup request
- req_wen  in  1  store lookup; marks line dirty on hit or refill
- req_cached  in  1  1 = cacheable access
- req_addr  in  ADDR_W  access address
- refill_done  in  1  AXI line fill complete for the pending miss
- hit  out  WAYS  one-hot hit way, valid in the response cycle
- miss  out  1  pending cacheable miss
- stallreq  out  1  equals miss
- victim  out  WAYS  one-hot way selected for replacement
- write_back  out  1  victim is valid and dirty
- axi_raddr  out  ADDR_W  line-aligned refill address if cached; raw address if uncached
- axi_waddr  out  ADDR_W  victim line address {victim tag, index, zeros}

Behaviour:
- Reset is asynchronous. All valid, dirty and PLRU bits clear, the request register clears, and every output is 0.
- Tag RAM per way: SETS x TAG_W with synchronous read and no reset. Its content is don't-care while the valid bit is 0.
- Stage 0: when req_en=1 and miss=0, latch addr/wen/cached and read the tags at the index.
- Stage 1 (next cycle): hit[w] = valid & (tag==tag_r) & cached_r & en_r & ~flush.
- Latency: one cycle from req_en to hit/miss.
- miss = en_r & cached_r & ~|hit & ~flush. miss holds while the miss is pending.
- While miss=1, new requests are ignored and the stage-1 registers hold.
- Victim selection:
  - lowest-index invalid way if one exists;
  - otherwise the PLRU way.
  - victim is stable for the whole miss.
- write_back = miss & valid[victim] & dirty[victim].
- refill_done while miss=1:
  - write tag_r into the victim way; valid=1, dirty=wen_r;
  - update PLRU to the victim;
  - re-read the index, so the next cycle gives hit on the victim way and miss=0.
- refill_done with no pending miss is ignored.
- Hit on way w:
  - update PLRU tree nodes so w becomes most recently used;
  - if wen_r, set dirty[w].
- Uncached request: hit=0, miss=0; tag, valid, dirty and PLRU are unchanged; axi_raddr = raw req_addr.
- flush:
  - forces hit=0, miss=0 and write_back=0 in the same cycle;
  - clears the pending request, so no state update happens;
  - flush together with refill_done: the refill is still written, and the result is not reported.
- PLRU: WAYS-1 bits per set. Node bit 0 means the left subtree is older. Victim search walks toward the older side.

Optional Feature:
- Macro: CACHE_TAG_INDEX_INV_EN.
- With the macro defined, add ports:
  - inv_en, in, 1
  - inv_wb, in, 1
  - inv_addr, in, ADDR_W
- inv_en clears valid and dirty in all ways at the inv_addr index, over 1 cycle, and has priority over a new request.
- If inv_wb=1 and a line is dirty: stallreq is asserted, write_back/axi_waddr are presented per dirty way in ascending order, and each is acknowledged by refill_done.
- Without the macro: no ports, no logic.

Decomposition:
- Package cache_pkg:
  - width functions (clog2-based OFF_W/IDX_W/TAG_W);
  - default WAYS/SETS/LINE_BYTES constants;
  - one-hot-to-index function.
- Sub-module plru_tree: combinational per-set victim and next-state from (bits, access way).

Test Plan:
- Reset, then read 0x0000_1040 cached -> cycle+1: miss=1, victim=0001, write_back=0, axi_raddr=0x0000_1040; refill_done -> next cycle hit=0001, miss=0.
- Fill 4 ways at index 2 (tags 1..4), hit tag 1, then miss tag 5 -> victim=0100 per PLRU (way 2 untouched); no write_back since nothing dirty.
- Store hit on way 1 (req_wen=1), then evict way 1 -> write_back=1, axi_waddr={tag,idx,5'b0} of way 1.
- Uncached read 0x1FC0_0004 -> hit=0, miss=0, axi_raddr=0x1FC0_0004; tag state unchanged.
- flush during pending miss, same cycle as refill_done -> miss=0 that cycle; the line becomes valid; the subsequent same-address lookup hits.
- Assert rst mid-miss -> all outputs 0 immediately; the next lookup to a previously filled line misses.
